// File: rtl/cache_pkg.sv
// Shared types, geometry and address-field helpers for the L1 data cache.
package cache_pkg;

    localparam int LINES          = 32;
    localparam int LINE_W         = 256;
    localparam int ADDR_W         = 32;
    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = LINE_W / WORD_W;
    localparam int BYTE_OFF_W     = 2;
    localparam int WORD_SEL_W     = $clog2(WORDS_PER_LINE);
    localparam int INDEX_W        = $clog2(LINES);
    localparam int OFFSET_W       = $clog2(LINE_W / 8);
    localparam int TAG_W          = ADDR_W - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITEBACK,
        ST_REFILL
    } state_e;

    // A line is a vector of words; word 0 occupies the least significant bits.
    typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return TAG_W'(a >> (OFFSET_W + INDEX_W));
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return INDEX_W'(a >> OFFSET_W);
    endfunction

    function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
        return WORD_SEL_W'(a >> BYTE_OFF_W);
    endfunction

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                    input logic [INDEX_W-1:0] idx);
        return {tag, idx, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag, valid, dirty and data storage for the direct-mapped cache.
// Reads are asynchronous; word writes and line fills land on the rising edge.
module dcache_sram
    import cache_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [INDEX_W-1:0] rd_idx_i,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic               rd_valid_o,
    output logic               rd_dirty_o,
    output line_t              rd_line_o,
    input  logic [INDEX_W-1:0] wr_idx_i,
    input  logic               word_we_i,
    input  logic [WORD_SEL_W-1:0] word_sel_i,
    input  logic [WORD_W-1:0]  word_data_i,
    input  logic               fill_i,
    input  logic [TAG_W-1:0]   fill_tag_i,
    input  line_t              fill_line_i
);

    logic [TAG_W-1:0] tag_q  [LINES];
    line_t            data_q [LINES];
    logic [LINES-1:0] valid_q, valid_d;
    logic [LINES-1:0] dirty_q, dirty_d;

    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_line_o  = data_q[rd_idx_i];
    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];

    // A fill makes the line valid and clean; a word store marks it dirty.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (fill_i) begin
            valid_d[wr_idx_i] = 1'b1;
            dirty_d[wr_idx_i] = 1'b0;
        end else if (word_we_i) begin
            dirty_d[wr_idx_i] = 1'b1;
        end
    end

    // Status bits are the only storage cleared by reset; dirty data is simply dropped.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays: written by a refill or by a single-word store.
    always_ff @(posedge clk_i) begin
        if (fill_i) begin
            tag_q[wr_idx_i]  <= fill_tag_i;
            data_q[wr_idx_i] <= fill_line_i;
        end else if (word_we_i) begin
            data_q[wr_idx_i][word_sel_i] <= word_data_i;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate L1 data cache controller.
// Looks up combinationally, stalls the core on a miss, and drives line
// write-backs and refills over the memory enable/write/ack handshake.
module dcache_ctrl
    import cache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [WORD_W-1:0] cpu_wdata_i,
    output logic [WORD_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i
);

    state_e             state_q, state_d;
    logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
    logic [INDEX_W-1:0] miss_idx_q, miss_idx_d;
    logic               mem_enable_q, mem_enable_d;
    logic               mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    line_t              mem_data_q, mem_data_d;

    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_W-1:0]    req_idx;
    logic [WORD_SEL_W-1:0] req_word;
    logic [TAG_W-1:0]      rd_tag;
    logic                  rd_valid;
    logic                  rd_dirty;
    line_t                 rd_line;
    logic                  hit;
    logic                  word_we;
    logic                  fill;
    logic [INDEX_W-1:0]    wr_idx;
    logic                  unused_addr_bits;

    assign req_tag  = addr_tag(cpu_addr_i);
    assign req_idx  = addr_index(cpu_addr_i);
    assign req_word = addr_word(cpu_addr_i);
    assign unused_addr_bits = ^cpu_addr_i[BYTE_OFF_W-1:0];

    assign hit         = rd_valid & (rd_tag == req_tag);
    assign cpu_rdata_o = hit ? rd_line[req_word] : '0;
    assign cpu_stall_o = cpu_req_i & ((state_q != ST_IDLE) | !hit);

    // Once the miss is latched, the refill targets the latched line, not the live address.
    assign wr_idx = (state_q == ST_REFILL) ? miss_idx_q : req_idx;

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

    dcache_sram u_sram (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .rd_idx_i    (req_idx),
        .rd_tag_o    (rd_tag),
        .rd_valid_o  (rd_valid),
        .rd_dirty_o  (rd_dirty),
        .rd_line_o   (rd_line),
        .wr_idx_i    (wr_idx),
        .word_we_i   (word_we),
        .word_sel_i  (req_word),
        .word_data_i (cpu_wdata_i),
        .fill_i      (fill),
        .fill_tag_i  (miss_tag_q),
        .fill_line_i (line_t'(mem_data_i))
    );

    // Next state, miss capture and the next value of the registered memory request.
    always_comb begin
        state_d      = state_q;
        miss_tag_d   = miss_tag_q;
        miss_idx_d   = miss_idx_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        word_we      = 1'b0;
        fill         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req_i) begin
                    if (hit) begin
                        word_we = cpu_we_i;
                    end else begin
                        miss_tag_d   = req_tag;
                        miss_idx_d   = req_idx;
                        mem_enable_d = 1'b1;
                        if (rd_valid && rd_dirty) begin
                            // Victim line and tag go straight into the request registers.
                            state_d     = ST_WRITEBACK;
                            mem_write_d = 1'b1;
                            mem_addr_d  = line_addr(rd_tag, req_idx);
                            mem_data_d  = rd_line;
                        end else begin
                            state_d     = ST_REFILL;
                            mem_write_d = 1'b0;
                            mem_addr_d  = line_addr(req_tag, req_idx);
                        end
                    end
                end
            end
            ST_WRITEBACK: begin
                if (mem_ack_i) begin
                    // Keep enable high: the refill follows with no idle cycle.
                    state_d     = ST_REFILL;
                    mem_write_d = 1'b0;
                    mem_addr_d  = line_addr(miss_tag_q, miss_idx_q);
                end
            end
            ST_REFILL: begin
                if (mem_ack_i) begin
                    fill         = 1'b1;
                    mem_enable_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller state and memory request registers; reset aborts any transaction.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            miss_tag_q   <= '0;
            miss_idx_q   <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            miss_tag_q   <= miss_tag_d;
            miss_idx_q   <= miss_idx_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

endmodule
